// File: rtl/vga_pkg.sv
// Shared defaults and grant-state encoding for the VGA glyph RAM arbiter.
package vga_pkg;
    localparam int AW_DEF = 6;
    localparam int DW_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DISP  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
endpackage

// File: rtl/arb_wr_fifo.sv
// Small synchronous FIFO, power-of-two depth; push while full and pop while empty are ignored.
module arb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 14
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/vga_rom_arbiter.sv
// Display-priority arbiter for the single-port glyph RAM; writer traffic is buffered and
// retired on idle display cycles. Optional statistics under VGA_ARB_STATS_EN.
module vga_rom_arbiter
    import vga_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int BLANK_ONLY = 0,
    parameter int STARVE_LIM = 2048
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          blank_i,
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic [DW-1:0] disp_q_o,
    output logic          disp_valid_o,
    input  logic          wr_valid_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ready_o,
    output logic          wr_starve_o,
    output logic          busy_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_wren_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_q_i
`ifdef VGA_ARB_STATS_EN
    ,
    output logic [15:0]   stat_wr_cnt_o,
    output logic [15:0]   stat_max_wait_o
`endif
);
    localparam int FW = AW + DW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [FW-1:0] head;
    logic          full, empty, push, pop;
    logic [CW-1:0] count, count_next;
    logic [1:0]    grant;
    logic          disp_valid_q;
    logic [SW-1:0] wait_q, wait_d;
    logic          starve_q, starve_d;

    arb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({wr_addr_i, wr_data_i}),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        grant = ST_IDLE;
        if (disp_req_i)
            grant = ST_DISP;
        else if (!empty && (BLANK_ONLY == 0 || blank_i))
            grant = ST_WRITE;
    end

    assign push        = wr_valid_i && !full;
    assign pop         = (grant == ST_WRITE);
    assign wr_ready_o  = !full;
    assign busy_o      = !empty;
    assign ram_wren_o  = pop;
    assign ram_addr_o  = pop ? head[FW-1:DW] : disp_addr_i;
    assign ram_wdata_o = head[DW-1:0];
    assign disp_q_o    = ram_q_i;
    assign disp_valid_o = disp_valid_q;
    assign wr_starve_o  = starve_q;
    assign count_next   = count + CW'(push) - CW'(pop);

    // Head wait time restarts on every retire; starve flag survives until the buffer drains.
    always_comb begin
        wait_d = wait_q;
        if (pop || empty)
            wait_d = '0;
        else if (wait_q != SW'(STARVE_LIM))
            wait_d = wait_q + 1'b1;
        starve_d = starve_q;
        if (count_next == '0)
            starve_d = 1'b0;
        else if (wait_d == SW'(STARVE_LIM))
            starve_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            disp_valid_q <= 1'b0;
            wait_q       <= '0;
            starve_q     <= 1'b0;
        end else begin
            disp_valid_q <= (grant == ST_DISP);
            wait_q       <= wait_d;
            starve_q     <= starve_d;
        end
    end

`ifdef VGA_ARB_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d, max_wait_q, max_wait_d, wait_sat;
    logic [31:0] wait_ext;

    assign wait_ext = 32'(wait_q);
    assign wait_sat = (wait_ext > 32'h0000_FFFF) ? 16'hFFFF : wait_ext[15:0];

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (pop && wr_cnt_q != 16'hFFFF)
            wr_cnt_d = wr_cnt_q + 16'd1;
        max_wait_d = max_wait_q;
        if (wait_sat > max_wait_q)
            max_wait_d = wait_sat;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt_q   <= '0;
            max_wait_q <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            max_wait_q <= max_wait_d;
        end
    end

    assign stat_wr_cnt_o   = wr_cnt_q;
    assign stat_max_wait_o = max_wait_q;
`endif
endmodule
